// File: rtl/encoder_rc5.sv
// ----------------------------------------------------------------------------
// encoder_rc5
//   Iterative RC5-32 block encryptor. One full round (A half then B half) is
//   computed per clock, so a block takes ROUNDS clocks from acceptance to
//   ciphertext. Round keys live in an internal register file loaded through a
//   simple write port while the encoder is idle.
//
// Ports
//   clk        : sole clock, rising-edge active
//   rst        : asynchronous, active-high reset
//   key_we     : round-key write strobe (honoured only while idle)
//   key_addr   : round-key index S[0..2*ROUNDS+1]; larger indices ignored
//   key_data   : round-key word
//   in_valid   : plaintext block offered on d_in
//   in_ready   : encoder idle and able to accept a block
//   d_in       : plaintext, A = d_in[63:32], B = d_in[31:0]
//   out_valid  : ciphertext on d_out is valid
//   out_ready  : downstream accepts the ciphertext
//   d_out      : ciphertext, A = d_out[63:32], B = d_out[31:0]
// ----------------------------------------------------------------------------
module encoder_rc5 #(
    parameter int unsigned ROUNDS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_we,
    input  logic [4:0]  key_addr,
    input  logic [31:0] key_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] d_out
);

    localparam int unsigned NKEYS      = 2 * ROUNDS + 2;
    localparam int unsigned AW         = $clog2(NKEYS);
    localparam logic [4:0]  LAST_KEY   = 5'(2 * ROUNDS + 1);
    localparam logic [4:0]  LAST_ROUND = 5'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_key [NKEYS];
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_round;
    logic [63:0] r_d_out;

    logic [AW-1:0] w_idx_a;
    logic [AW-1:0] w_idx_b;
    logic [AW-1:0] w_wr_idx;
    logic          w_key_wr;
    logic          w_accept;
    logic [31:0]   w_a_new;
    logic [31:0]   w_b_new;

    // Rotate left by the low five bits: take the upper word of {x,x} << n.
    function automatic logic [31:0] f_rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    // ------------------------------------------------------------------------
    // Round datapath: the B half uses the freshly computed A of the same round.
    // ------------------------------------------------------------------------
    assign w_idx_a  = AW'({r_round, 1'b0});
    assign w_idx_b  = AW'({r_round, 1'b1});
    assign w_a_new  = f_rotl(r_a ^ r_b, r_b[4:0]) + r_key[w_idx_a];
    assign w_b_new  = f_rotl(r_b ^ w_a_new, w_a_new[4:0]) + r_key[w_idx_b];

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_key_wr = (r_state == S_IDLE) && key_we && (key_addr <= LAST_KEY);
    assign w_wr_idx = AW'(key_addr);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_ROUND;
                end
            end
            S_ROUND: begin
                if (r_round == LAST_ROUND) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Round-key register file. A write coinciding with acceptance lands on the
    // same edge, so whitening reads the old value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NKEYS; k++) begin
                r_key[k] <= '0;
            end
        end else if (w_key_wr) begin
            r_key[w_wr_idx] <= key_data;
        end
    end

    // ------------------------------------------------------------------------
    // Working registers, round counter and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_round <= '0;
            r_d_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= d_in[63:32] + r_key[0];
                        r_b     <= d_in[31:0]  + r_key[1];
                        r_round <= 5'd1;
                    end
                end
                S_ROUND: begin
                    r_a     <= w_a_new;
                    r_b     <= w_b_new;
                    r_round <= r_round + 5'd1;
                    if (r_round == LAST_ROUND) begin
                        r_d_out <= {w_a_new, w_b_new};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign d_out = r_d_out;

endmodule

// File: tb/tb_encoder_rc5.sv
module tb_encoder_rc5;

    localparam int unsigned NR    = 12;
    localparam int unsigned NKEYS = 2 * NR + 2;

    logic        clk;
    logic        rst;
    logic        key_we;
    logic [4:0]  key_addr;
    logic [31:0] key_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] d_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] d_out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference state: key table as the bench believes it and last ciphertext.
    logic [31:0] m_key [NKEYS];
    logic [63:0] last_ct;

    encoder_rc5 #(.ROUNDS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_we    (key_we),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        int unsigned s;
        s = n % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [63:0] model_enc(input logic [63:0] pt);
        logic [31:0] a;
        logic [31:0] b;
        a = pt[63:32] + m_key[0];
        b = pt[31:0]  + m_key[1];
        for (int i = 1; i <= int'(NR); i++) begin
            a = rotl(a ^ b, b % 32) + m_key[2*i];
            b = rotl(b ^ a, a % 32) + m_key[2*i+1];
        end
        return {a, b};
    endfunction

    // RC5-32/NR/16 key expansion for an all-zero 16-byte secret key.
    task automatic zero_key_schedule(output logic [31:0] s [NKEYS]);
        logic [31:0] l [4];
        logic [31:0] a;
        logic [31:0] b;
        int unsigned i;
        int unsigned j;
        s[0] = 32'hB7E15163;
        for (int k = 1; k < int'(NKEYS); k++) s[k] = s[k-1] + 32'h9E3779B9;
        for (int k = 0; k < 4; k++) l[k] = '0;
        a = '0; b = '0; i = 0; j = 0;
        for (int k = 0; k < 3 * int'(NKEYS); k++) begin
            s[i] = rotl(s[i] + a + b, 3);
            a = s[i];
            l[j] = rotl(l[j] + a + b, (a + b) % 32);
            b = l[j];
            i = (i + 1) % NKEYS;
            j = (j + 1) % 4;
        end
    endtask

    // ---------------- stimulus helpers (entered and left at a negedge) ----------------
    task automatic write_key(input logic [4:0] addr, input logic [31:0] data);
        key_we   = 1'b1;
        key_addr = addr;
        key_data = data;
        @(negedge clk);
        key_we   = 1'b0;
    endtask

    task automatic drive_junk();
        key_we   = 1'b1;
        key_addr = 5'($urandom_range(0, 31));
        key_data = $urandom;
    endtask

    task automatic run_block(input logic [63:0] pt, input logic [63:0] exp,
                             input int unsigned stalls, input bit junk,
                             input bit acc_wr, input logic [31:0] acc_data);
        int unsigned lat;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        d_in     = pt;
        in_valid = 1'b1;
        if (acc_wr) begin
            key_we   = 1'b1;
            key_addr = 5'd0;
            key_data = acc_data;
        end
        @(negedge clk);
        in_valid = 1'b0;
        key_we   = 1'b0;
        d_in     = {$urandom, $urandom};
        if (acc_wr) m_key[0] = acc_data;
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk("dout_hold_round", d_out, last_ct);
            if (junk) drive_junk();
            d_in = {$urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(NR));
        chk("ciphertext", d_out, exp);
        last_ct = exp;
        for (int unsigned s = 0; s < stalls; s++) begin
            if (junk) drive_junk();
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", d_out, exp);
        end
        if (junk) drive_junk();
        out_ready = 1'b1;
        @(negedge clk);
        chk("valid_clear", 64'(out_valid), 64'd0);
        chk("idle_return", 64'(in_ready), 64'd1);
        chk("dout_after", d_out, exp);
        out_ready = 1'b0;
        key_we    = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] sched [NKEYS];
        logic [63:0] pt;
        logic [63:0] q [$];
        int unsigned last_acc;
        int unsigned n_acc;

        rst = 1'b1; key_we = 1'b0; key_addr = '0; key_data = '0;
        in_valid = 1'b0; d_in = '0; out_ready = 1'b0;
        for (int k = 0; k < int'(NKEYS); k++) m_key[k] = '0;
        last_ct = '0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_d_out", d_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero keys and plaintext, single-cycle output pulse.
        run_block(64'd0, 64'h0, 0, 1'b0, 1'b0, 32'd0);

        // Standard test vector from the zero-key schedule.
        zero_key_schedule(sched);
        for (int k = 0; k < int'(NKEYS); k++) begin
            write_key(5'(k), sched[k]);
            m_key[k] = sched[k];
        end
        run_block(64'd0, 64'hEEDBA5216D8F4B15, 2, 1'b0, 1'b0, 32'd0);

        // Key write on the acceptance edge: whitening sees the old S[0].
        pt = {$urandom, $urandom};
        run_block(pt, model_enc(pt), 1, 1'b0, 1'b1, $urandom);
        pt = {$urandom, $urandom};
        run_block(pt, model_enc(pt), 0, 1'b0, 1'b0, 32'd0);

        // Out-of-range writes in IDLE and writes during ROUND/DONE are ignored.
        for (int a = 26; a < 32; a++) write_key(5'(a), $urandom);
        pt = {$urandom, $urandom};
        run_block(pt, model_enc(pt), 3, 1'b1, 1'b0, 32'd0);

        // Random keys, random blocks, random backpressure.
        for (int k = 0; k < int'(NKEYS); k++) begin
            m_key[k] = $urandom;
            write_key(5'(k), m_key[k]);
        end
        for (int n = 0; n < 1000; n++) begin
            bit aw;
            pt = {$urandom, $urandom};
            aw = (n % 97 == 5);
            run_block(pt, model_enc(pt), $urandom_range(0, 3), (n % 8 == 3), aw, $urandom);
        end

        // in_valid held high with out_ready high: one acceptance every NR+2 clocks.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        n_acc     = 0;
        last_acc  = 0;
        for (int unsigned cyc = 0; cyc < 4 * (NR + 2); cyc++) begin
            d_in = {$urandom, $urandom};
            if (in_ready) begin
                if (n_acc > 0) chk("accept_gap", 64'(cyc - last_acc), 64'(NR + 2));
                q.push_back(model_enc(d_in));
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid) begin
                if (q.size() == 0) chk("stream_spurious", 64'd1, 64'd0);
                else chk("stream_ct", d_out, q.pop_front());
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_accepts", 64'(n_acc), 64'd4);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Reset during round 6 aborts the block and clears the keys.
        in_valid = 1'b1;
        d_in     = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_d_out", d_out, 64'd0);
        @(negedge clk);
        chk("abort_still_quiet", 64'(out_valid), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < int'(NKEYS); k++) m_key[k] = '0;
        last_ct = '0;
        pt = {$urandom, $urandom};
        run_block(pt, model_enc(pt), 1, 1'b0, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/encoder_rc5.md
ENCODER_RC5 -- requirements
Module: encoder_rc5

Interface
REQ-001 SHALL provide parameter ROUNDS, default 12, number of RC5 rounds (legal range 1..12); round-key storage is 2*ROUNDS+2 words.
REQ-002 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port key_we  input  1  round-key write strobe.
REQ-005 SHALL provide port key_addr  input  5  round-key index S[0..2*ROUNDS+1].
REQ-006 SHALL provide port key_data  input  32  round-key word.
REQ-007 SHALL provide port in_valid  input  1  plaintext block offered.
REQ-008 SHALL provide port in_ready  output  1  encoder idle, able to accept a block.
REQ-009 SHALL provide port d_in  input  64  plaintext, A = d_in[63:32], B = d_in[31:0].
REQ-010 SHALL provide port out_valid  output  1  ciphertext on d_out valid.
REQ-011 SHALL provide port out_ready  input  1  downstream accepts ciphertext.
REQ-012 SHALL provide port d_out  output  64  ciphertext, A = d_out[63:32], B = d_out[31:0].

Function
REQ-013 SHALL implement RC5-32 encryption: A=A+S[0], B=B+S[1]; for i=1..ROUNDS: A=((A^B)<<<B[4:0])+S[2i]; B=((B^A)<<<A[4:0])+S[2i+1]; all additions modulo 2^32, rotates left by low 5 bits, B step uses the updated A.
REQ-014 SHALL hold round keys in an internal register file of 2*ROUNDS+2 x 32 bits, written on a rising edge when key_we=1 and state is IDLE.
REQ-015 SHALL ignore key writes with key_addr > 2*ROUNDS+1 and key writes while state is not IDLE.
REQ-016 SHALL use three states: IDLE, ROUND, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE.
REQ-018 IDLE: on edge with in_valid=1, SHALL load a_reg=d_in[63:32]+S[0], b_reg=d_in[31:0]+S[1], round counter=1, go to ROUND; else remain.
REQ-019 ROUND: SHALL compute one full round (A then B) per clock; after the edge applying round ROUNDS, SHALL copy {A,B} to d_out, set out_valid=1, go to DONE.
REQ-020 SHALL assert out_valid exactly ROUNDS clocks after the acceptance edge (12 for default).
REQ-021 DONE: SHALL hold d_out and out_valid stable while out_ready=0; on edge with out_ready=1 SHALL clear out_valid and return to IDLE.
REQ-022 SHALL NOT accept a new block in the DONE-exit cycle; next acceptance earliest one clock after return to IDLE.
REQ-023 in_valid SHALL be ignored outside IDLE; d_in is sampled only on the acceptance edge.
REQ-024 Simultaneous key_we and acceptance in IDLE: the key write SHALL take effect, whitening SHALL use the pre-write key value.
REQ-025 d_out SHALL change only on the transition into DONE.

Reset
REQ-026 On rst=1, SHALL immediately (asynchronously) force state IDLE, in_ready=1, out_valid=0, d_out=0, a_reg=b_reg=0, round counter=0, all round keys=0.
REQ-027 Reset asserted mid-encryption or in DONE SHALL abort the block with no output; first acceptance allowed on the first edge after rst deasserts.

Verification
REQ-028 Keys all 0, d_in=64'h0, out_ready=1 -> out_valid high 12 clocks after acceptance, d_out=64'h0000000000000000, one-cycle pulse.
REQ-029 Keys loaded from the RC5-32/12/16 schedule of an all-zero 16-byte key (software model), d_in=64'h0 -> d_out=64'hEEDBA5216D8F4B15.
REQ-030 Random keys and 1000 random blocks vs software model, random out_ready backpressure -> every d_out matches, d_out stable while out_valid=1 and out_ready=0.
REQ-031 key_we pulses during ROUND and DONE, and with key_addr=26..31 in IDLE -> ciphertext unchanged vs run without those writes.
REQ-032 rst pulsed at round 6 -> out_valid stays 0, in_ready=1 immediately, next block encrypts correctly with keys reset to 0.
REQ-033 in_valid held high continuously with out_ready=1 -> one block accepted per ROUNDS+2 clocks, in_ready low from acceptance until return to IDLE.
